c1_pool_scheduler: RTL and testbench
====================================

# c1_pool_scheduler

Sequences the C1 convolution/pooling pipeline for one 28x28x6 frame. It issues per-row requests to the conv engine under a credit scheme sized to the pooling unit's two 2-row ping-pong buffers, and counts conv beats and pooled beats. It also generates S2 feature-memory write addresses (14x14, six 8-bit channels packed per word) and signals frame completion. It sits between the layer-level controller and the conv_5x5_pe / C1 max-pooling datapath.

## Interface
- CONV_WIDTH, 28, conv output columns per row
- CONV_HEIGHT, 28, conv output rows per frame
- POOL_WIDTH, 14, pooled columns per row (CONV_WIDTH/2)
- POOL_HEIGHT, 14, pooled rows per frame (CONV_HEIGHT/2)
- ADDR_W, 8, S2 address width (must hold POOL_WIDTH*POOL_HEIGHT-1)
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- frame_start  in  1  one-cycle pulse; starts a frame when idle
- busy  out  1  high from accepted frame_start until frame_done cycle inclusive
- frame_done  out  1  one-cycle pulse when all 196 pooled words are written
- row_req  out  1  one-cycle pulse; conv engine produces next output row
- row_idx  out  5  index (0..27) of the row requested, valid with row_req
- conv_valid  in  1  one conv output beat (all 6 channels)
- mp_valid  in  1  one pooled beat from the pooling unit
- mp_data  in  48  {ch5..ch0}, 8 bits each
- s2_we  out  1  S2 memory write strobe
- s2_addr  out  ADDR_W  pool_row*POOL_WIDTH + pool_col
- s2_wdata  out  48  mp_data registered
- err  out  1  sticky protocol error; cleared only by reset or accepted frame_start
- perf_cycles  out  16  frame cycle count (see Configuration)

## Operation
- State machine: IDLE, ISSUE, RECV, DRAIN, DONE.
- IDLE: frame_start -> clear counters, err, credit=4; go ISSUE. frame_start in any other state is ignored.
- ISSUE: if credit>0, pulse row_req with row_idx=rows_issued, increment rows_issued, decrement credit, go RECV; else hold (no pulse).
- RECV: count conv_valid beats to CONV_WIDTH. On the 28th beat, go DRAIN if rows_issued==CONV_HEIGHT, else go ISSUE.
- DRAIN: wait until pooled_cnt==196; go DONE.
- DONE: frame_done=1 for one cycle; go IDLE.
- Credit: 4 row slots (two 2-row buffers). Each completed pooled row (POOL_WIDTH mp_valid beats) returns 2 credits. Credit saturates at 4; a return that would exceed 4 sets err.
- A credit return and a row_req in the same cycle apply both (net +1).
- Pooled counters: pool_col 0..13 wraps to 0 and increments pool_row; pooled_cnt 0..196.
- mp_valid in IDLE, or with pooled_cnt==196, sets err; no write is issued.
- conv_valid outside RECV sets err and is ignored.
- Arithmetic: s2_addr computed from counters, not accumulated. The 8-bit max 195 fits ADDR_W=8.

## Timing
- Reset values: busy=0, frame_done=0, row_req=0, row_idx=0, s2_we=0, s2_addr=0, s2_wdata=0, err=0, perf_cycles=0; state IDLE, credit=4.
- frame_start in cycle N -> busy=1 at N+1; first row_req at N+1 (ISSUE entered at N+1, pulse combinationally qualified by state).
- conv_valid 28th beat at cycle M -> next row_req no earlier than M+1 (credit permitting).
- mp_valid at cycle K -> s2_we/s2_addr/s2_wdata valid at K+1, for exactly one cycle per beat; back-to-back beats are supported.
- Final pooled beat at K -> last s2_we at K+1; DRAIN sees pooled_cnt==196 at K+1; frame_done at K+2; busy low at K+3.
- rst_n low mid-frame: all state cleared on that edge. Pending beats are dropped and no write is issued.

## Configuration
- C1_SCHED_PERF_EN defined: perf_cycles clears on an accepted frame_start, increments each busy cycle, saturates at 0xFFFF, and holds after frame_done until the next frame.
- Undefined: counter logic is absent and perf_cycles is tied to 0.

## Test plan
- Reset, then frame_start with an ideal model (28 conv beats 2 cycles after each row_req; 14 mp beats after every 2 rows) -> 28 row_req with row_idx 0..27, 196 writes at addr 0..195 in order, one frame_done, err=0.
- Withhold all mp_valid -> exactly 4 row_req issued (row_idx 0..3), then stall in ISSUE with busy=1. Then supply 14 mp beats -> row_req resumes with row_idx=4.
- mp_valid with mp_data=0x0605_0403_0201 as the 15th pooled beat -> write at addr 14 with that data one cycle later.
- conv_valid asserted in IDLE -> err=1 and stays 1; the next frame_start clears it.
- Pull rst_n low after row 10 -> all outputs return to reset values next edge; a new frame_start restarts at row_idx=0, addr=0.
- With C1_SCHED_PERF_EN, ideal frame of known length L cycles -> perf_cycles==L after frame_done. Without the macro -> perf_cycles==0 throughout.

Source files
------------

// File: rtl/c1_pool_scheduler.sv
// rtl/c1_pool_scheduler.sv - C1 conv/pool frame sequencer: credit-gated row requests, pooled-beat counting, S2 write addressing
// Optional feature macro: C1_SCHED_PERF_EN (frame busy-cycle counter on perf_cycles; tied to 0 when undefined).
module c1_pool_scheduler #(
   parameter int CONV_WIDTH  = 28,
   parameter int CONV_HEIGHT = 28,
   parameter int POOL_WIDTH  = 14,
   parameter int POOL_HEIGHT = 14,
   parameter int ADDR_W      = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              frame_start,
   output logic              busy,
   output logic              frame_done,
   output logic              row_req,
   output logic [4:0]        row_idx,
   input  logic              conv_valid,
   input  logic              mp_valid,
   input  logic [47:0]       mp_data,
   output logic              s2_we,
   output logic [ADDR_W-1:0] s2_addr,
   output logic [47:0]       s2_wdata,
   output logic              err,
   output logic [15:0]       perf_cycles
);

   localparam int POOL_TOTAL = POOL_WIDTH * POOL_HEIGHT;
   localparam int BEAT_W     = $clog2(CONV_WIDTH);
   localparam int PCOL_W     = $clog2(POOL_WIDTH);
   localparam int PROW_W     = $clog2(POOL_HEIGHT + 1);
   localparam int PCNT_W     = $clog2(POOL_TOTAL + 1);
   // Four row slots: the pooling unit holds two 2-row ping-pong buffers.
   localparam logic [2:0] CREDIT_MAX = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_RECV  = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [2:0]          credit_q, credit_d;
   logic [4:0]          rows_issued_q, rows_issued_d;
   logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
   logic [PCOL_W-1:0]   pool_col_q, pool_col_d;
   logic [PROW_W-1:0]   pool_row_q, pool_row_d;
   logic [PCNT_W-1:0]   pooled_cnt_q, pooled_cnt_d;
   logic                err_q, err_d;
   logic                s2_we_q, s2_we_d;
   logic [ADDR_W-1:0]   s2_addr_q, s2_addr_d;
   logic [47:0]         s2_wdata_q, s2_wdata_d;

   logic                start;
   logic                take;
   logic                mp_ok;
   logic                pool_row_done;
   logic                proto_err;
   logic                credit_ovf;
   logic [3:0]          credit_sum;

   // Next state, credit accounting, pooled counters and S2 write strobe.
   always_comb begin
      state_d       = state_q;
      credit_d      = credit_q;
      rows_issued_d = rows_issued_q;
      beat_cnt_d    = beat_cnt_q;
      pool_col_d    = pool_col_q;
      pool_row_d    = pool_row_q;
      pooled_cnt_d  = pooled_cnt_q;
      err_d         = err_q;
      s2_we_d       = 1'b0;
      s2_addr_d     = s2_addr_q;
      s2_wdata_d    = s2_wdata_q;

      start         = (state_q == S_IDLE) && frame_start;
      take          = (state_q == S_ISSUE) && (credit_q != 3'd0);
      mp_ok         = mp_valid && (state_q != S_IDLE) &&
                      (pooled_cnt_q != PCNT_W'(POOL_TOTAL));
      pool_row_done = mp_ok && (pool_col_q == PCOL_W'(POOL_WIDTH - 1));
      proto_err     = (mp_valid && !mp_ok) || (conv_valid && (state_q != S_RECV));

      // Return and request in the same cycle net out; an over-return is a protocol error.
      credit_sum    = {1'b0, credit_q} + (pool_row_done ? 4'd2 : 4'd0) - (take ? 4'd1 : 4'd0);
      credit_ovf    = credit_sum > {1'b0, CREDIT_MAX};
      credit_d      = credit_ovf ? CREDIT_MAX : credit_sum[2:0];

      if (mp_ok) begin
         s2_we_d      = 1'b1;
         s2_addr_d    = ADDR_W'(pool_row_q) * ADDR_W'(POOL_WIDTH) + ADDR_W'(pool_col_q);
         s2_wdata_d   = mp_data;
         pooled_cnt_d = pooled_cnt_q + PCNT_W'(1);
         if (pool_row_done) begin
            pool_col_d = '0;
            pool_row_d = pool_row_q + PROW_W'(1);
         end else begin
            pool_col_d = pool_col_q + PCOL_W'(1);
         end
      end

      case (state_q)
         S_IDLE: begin
            if (frame_start) begin
               state_d       = S_ISSUE;
               credit_d      = CREDIT_MAX;
               rows_issued_d = '0;
               beat_cnt_d    = '0;
               pool_col_d    = '0;
               pool_row_d    = '0;
               pooled_cnt_d  = '0;
            end
         end
         S_ISSUE: begin
            if (take) begin
               rows_issued_d = rows_issued_q + 5'd1;
               state_d       = S_RECV;
            end
         end
         S_RECV: begin
            if (conv_valid) begin
               if (beat_cnt_q == BEAT_W'(CONV_WIDTH - 1)) begin
                  beat_cnt_d = '0;
                  state_d    = (rows_issued_q == 5'(CONV_HEIGHT)) ? S_DRAIN : S_ISSUE;
               end else begin
                  beat_cnt_d = beat_cnt_q + BEAT_W'(1);
               end
            end
         end
         S_DRAIN: begin
            if (pooled_cnt_q == PCNT_W'(POOL_TOTAL)) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // A new frame clears the sticky error, but a fault in that same cycle still lands.
      err_d = (start ? 1'b0 : err_q) | proto_err | credit_ovf;
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         credit_q      <= CREDIT_MAX;
         rows_issued_q <= '0;
         beat_cnt_q    <= '0;
         pool_col_q    <= '0;
         pool_row_q    <= '0;
         pooled_cnt_q  <= '0;
         err_q         <= 1'b0;
         s2_we_q       <= 1'b0;
         s2_addr_q     <= '0;
         s2_wdata_q    <= '0;
      end else begin
         state_q       <= state_d;
         credit_q      <= credit_d;
         rows_issued_q <= rows_issued_d;
         beat_cnt_q    <= beat_cnt_d;
         pool_col_q    <= pool_col_d;
         pool_row_q    <= pool_row_d;
         pooled_cnt_q  <= pooled_cnt_d;
         err_q         <= err_d;
         s2_we_q       <= s2_we_d;
         s2_addr_q     <= s2_addr_d;
         s2_wdata_q    <= s2_wdata_d;
      end
   end

   assign busy       = (state_q != S_IDLE);
   assign frame_done = (state_q == S_DONE);
   assign row_req    = take;
   assign row_idx    = rows_issued_q;
   assign s2_we      = s2_we_q;
   assign s2_addr    = s2_addr_q;
   assign s2_wdata   = s2_wdata_q;
   assign err        = err_q;

`ifdef C1_SCHED_PERF_EN
   logic [15:0] perf_q, perf_d;

   // Busy-cycle counter: cleared by an accepted start, saturating, frozen while idle.
   always_comb begin
      perf_d = perf_q;
      if (start) begin
         perf_d = 16'd0;
      end else if (busy && (perf_q != 16'hFFFF)) begin
         perf_d = perf_q + 16'd1;
      end
   end

   // Perf counter register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_q <= 16'd0;
      end else begin
         perf_q <= perf_d;
      end
   end

   assign perf_cycles = perf_q;
`else
   assign perf_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_c1_pool_scheduler.sv
// tb/tb_c1_pool_scheduler.sv - directed vector table plus frame-level sequences for c1_pool_scheduler
module tb_c1_pool_scheduler;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        frame_start;
   logic        busy;
   logic        frame_done;
   logic        row_req;
   logic [4:0]  row_idx;
   logic        conv_valid;
   logic        mp_valid;
   logic [47:0] mp_data;
   logic        s2_we;
   logic [7:0]  s2_addr;
   logic [47:0] s2_wdata;
   logic        err;
   logic [15:0] perf_cycles;

   int n_vec = 0;
   int n_err = 0;

`ifdef C1_SCHED_PERF_EN
   localparam logic [15:0] EXP_PERF = 16'd856;
`else
   localparam logic [15:0] EXP_PERF = 16'd0;
`endif

   c1_pool_scheduler dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .frame_start (frame_start),
      .busy        (busy),
      .frame_done  (frame_done),
      .row_req     (row_req),
      .row_idx     (row_idx),
      .conv_valid  (conv_valid),
      .mp_valid    (mp_valid),
      .mp_data     (mp_data),
      .s2_we       (s2_we),
      .s2_addr     (s2_addr),
      .s2_wdata    (s2_wdata),
      .err         (err),
      .perf_cycles (perf_cycles)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        fs;
      logic        cv;
      logic        mv;
      logic [47:0] md;
      logic        e_busy;
      logic        e_rreq;
      logic        chk_all;
      logic [4:0]  e_ridx;
      logic        e_we;
      logic [7:0]  e_addr;
      logic [47:0] e_wdata;
      logic        e_err;
      logic        e_done;
   } vec_t;

   // Environment model state
   int cyc;
   int rows_seen;
   int conv_wait;
   int conv_left;
   int rows_done;
   int mp_pending;
   int mp_sent;
   int wr_count;
   int done_count;
   int done_iter;
   bit mp_en;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [47:0] exp_data(input int w);
      if (w == 14) return 48'h0605_0403_0201;
      return {16'hA5C3, 16'(w), 16'(w * 7 + 1)};
   endfunction

   task automatic do_reset();
      rst_n       = 1'b0;
      frame_start = 1'b0;
      conv_valid  = 1'b0;
      mp_valid    = 1'b0;
      mp_data     = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic reset_model();
      cyc        = 0;
      rows_seen  = 0;
      conv_wait  = 0;
      conv_left  = 0;
      rows_done  = 0;
      mp_pending = 0;
      mp_sent    = 0;
      wr_count   = 0;
      done_count = 0;
      done_iter  = 0;
      mp_en      = 1'b0;
   endtask

   task automatic start_frame();
      frame_start = 1'b1;
      @(posedge clk);
      #1 frame_start = 1'b0;
      cyc = 1;
   endtask

   // One cycle: observe outputs settled after the last edge, then drive the next inputs.
   task automatic step();
      if (row_req) begin
         chk("row_idx", 64'(row_idx), 64'(rows_seen));
         rows_seen++;
         conv_wait = 2;
         conv_left = 28;
      end
      if (s2_we) begin
         chk("s2_addr", 64'(s2_addr), 64'(wr_count));
         chk("s2_wdata", 64'(s2_wdata), 64'(exp_data(wr_count)));
         wr_count++;
      end
      if (frame_done) begin
         done_count++;
         done_iter = cyc;
      end
      conv_valid = 1'b0;
      mp_valid   = 1'b0;
      mp_data    = '0;
      if (mp_pending > 0) begin
         mp_valid = 1'b1;
         mp_data  = exp_data(mp_sent);
         mp_sent++;
         mp_pending--;
      end
      if (conv_left > 0) begin
         if (conv_wait > 0) begin
            conv_wait--;
         end else begin
            conv_valid = 1'b1;
            conv_left--;
            if (conv_left == 0) begin
               rows_done++;
               if (mp_en && (rows_done % 2 == 0)) mp_pending += 14;
            end
         end
      end
      @(posedge clk);
      #1 cyc++;
   endtask

   task automatic ideal_frame(input string tag);
      reset_model();
      mp_en = 1'b1;
      start_frame();
      while (done_count == 0 && cyc < 3000) step();
      chk({tag, "_done_count"}, 64'(done_count), 64'd1);
      chk({tag, "_done_cycle"}, 64'(done_iter), 64'd856);
      chk({tag, "_rows"}, 64'(rows_seen), 64'd28);
      chk({tag, "_writes"}, 64'(wr_count), 64'd196);
      chk({tag, "_err"}, 64'(err), 64'd0);
      chk({tag, "_busy_after"}, 64'(busy), 64'd0);
      chk({tag, "_done_pulse"}, 64'(frame_done), 64'd0);
      chk({tag, "_perf"}, 64'(perf_cycles), 64'(EXP_PERF));
   endtask

   initial begin
      vec_t tbl [9];
      //           fs    cv    mv    md               busy  rreq  all   ridx   we    addr   wdata            err   done
      tbl[0] = '{1'b0, 1'b1, 1'b0, 48'h0,           1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 8'd0, 48'h0,           1'b0, 1'b0};
      tbl[1] = '{1'b0, 1'b0, 1'b0, 48'h0,           1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 8'd0, 48'h0,           1'b1, 1'b0};
      tbl[2] = '{1'b0, 1'b0, 1'b1, 48'hDEAD_BEEF_0001, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 8'd0, 48'h0,        1'b1, 1'b0};
      tbl[3] = '{1'b1, 1'b0, 1'b0, 48'h0,           1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 8'd0, 48'h0,           1'b1, 1'b0};
      tbl[4] = '{1'b0, 1'b0, 1'b0, 48'h0,           1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 8'd0, 48'h0,           1'b0, 1'b0};
      tbl[5] = '{1'b0, 1'b0, 1'b1, 48'h1122_3344_5566, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 8'd0, 48'h0,        1'b0, 1'b0};
      tbl[6] = '{1'b1, 1'b0, 1'b0, 48'h0,           1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 8'd0, 48'h1122_3344_5566, 1'b0, 1'b0};
      tbl[7] = '{1'b0, 1'b1, 1'b0, 48'h0,           1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 8'd0, 48'h0,           1'b0, 1'b0};
      tbl[8] = '{1'b0, 1'b0, 1'b0, 48'h0,           1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 8'd0, 48'h0,           1'b0, 1'b0};

      do_reset();
      for (int i = 0; i < 9; i++) begin
         chk($sformatf("v%0d_busy", i), 64'(busy), 64'(tbl[i].e_busy));
         chk($sformatf("v%0d_row_req", i), 64'(row_req), 64'(tbl[i].e_rreq));
         chk($sformatf("v%0d_err", i), 64'(err), 64'(tbl[i].e_err));
         chk($sformatf("v%0d_s2_we", i), 64'(s2_we), 64'(tbl[i].e_we));
         chk($sformatf("v%0d_frame_done", i), 64'(frame_done), 64'(tbl[i].e_done));
         if (tbl[i].chk_all || tbl[i].e_rreq)
            chk($sformatf("v%0d_row_idx", i), 64'(row_idx), 64'(tbl[i].e_ridx));
         if (tbl[i].chk_all || tbl[i].e_we) begin
            chk($sformatf("v%0d_s2_addr", i), 64'(s2_addr), 64'(tbl[i].e_addr));
            chk($sformatf("v%0d_s2_wdata", i), 64'(s2_wdata), 64'(tbl[i].e_wdata));
         end
         if (tbl[i].chk_all)
            chk($sformatf("v%0d_perf", i), 64'(perf_cycles), 64'd0);
         frame_start = tbl[i].fs;
         conv_valid  = tbl[i].cv;
         mp_valid    = tbl[i].mv;
         mp_data     = tbl[i].md;
         @(posedge clk);
         #1;
      end
      frame_start = 1'b0;
      conv_valid  = 1'b0;
      mp_valid    = 1'b0;

      // Full frame with an ideal conv engine and pooling unit
      do_reset();
      ideal_frame("ideal");

      // Withhold pooled beats: credit runs out after four rows
      do_reset();
      reset_model();
      start_frame();
      repeat (300) step();
      chk("stall_rows", 64'(rows_seen), 64'd4);
      chk("stall_busy", 64'(busy), 64'd1);
      chk("stall_row_req", 64'(row_req), 64'd0);
      mp_pending = 14;
      repeat (20) step();
      chk("resume_rows", 64'(rows_seen), 64'd5);
      chk("resume_writes", 64'(wr_count), 64'd14);
      // 15th pooled beat lands at address 14 one cycle later, for one cycle only
      mp_pending = 1;
      step();
      chk("beat15_we", 64'(s2_we), 64'd1);
      chk("beat15_addr", 64'(s2_addr), 64'd14);
      chk("beat15_data", 64'(s2_wdata), 64'h0000_0605_0403_0201);
      step();
      chk("beat15_we_drop", 64'(s2_we), 64'd0);
      chk("stall_err", 64'(err), 64'd0);

      // Reset mid-frame after row 10, then a clean restart
      do_reset();
      reset_model();
      mp_en = 1'b1;
      start_frame();
      while (rows_seen < 11 && cyc < 2000) step();
      chk("midrst_reach_row10", 64'(rows_seen), 64'd11);
      repeat (5) step();
      rst_n      = 1'b0;
      conv_valid = 1'b1;
      mp_valid   = 1'b1;
      mp_data    = 48'hFFFF_FFFF_FFFF;
      @(posedge clk);
      #1;
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_frame_done", 64'(frame_done), 64'd0);
      chk("midrst_row_req", 64'(row_req), 64'd0);
      chk("midrst_row_idx", 64'(row_idx), 64'd0);
      chk("midrst_s2_we", 64'(s2_we), 64'd0);
      chk("midrst_s2_addr", 64'(s2_addr), 64'd0);
      chk("midrst_s2_wdata", 64'(s2_wdata), 64'd0);
      chk("midrst_err", 64'(err), 64'd0);
      chk("midrst_perf", 64'(perf_cycles), 64'd0);
      rst_n      = 1'b1;
      conv_valid = 1'b0;
      mp_valid   = 1'b0;
      mp_data    = '0;
      @(posedge clk);
      #1;
      ideal_frame("restart");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
